// File: rtl/uart_rx.sv
// 8N1-style UART receiver driven by a shared 16x oversampling tick.
// Synchronises rx, validates the start bit at mid-bit and samples data/stop once per bit.
`timescale 1ns/1ps
module uart_rx #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick_16x,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned BIT_CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned TICK_W    = 4;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [TICK_W-1:0]    MID_TICK  = TICK_W'(7);
    localparam logic [TICK_W-1:0]    LAST_TICK = TICK_W'(15);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic                   w_rx_s;
    logic [TICK_W-1:0]      r_tick_cnt;
    logic [TICK_W-1:0]      w_tick_cnt_next;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [BIT_CNT_W-1:0]   w_bit_cnt_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic [DATA_BITS-1:0]   w_rx_data_next;
    logic                   w_rx_valid_next;
    logic                   w_frame_err_next;

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // Input synchroniser; resets to idle-high so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
            r_rx_prev <= w_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            rx_data    <= w_rx_data_next;
            rx_valid   <= w_rx_valid_next;
            frame_err  <= w_frame_err_next;
            busy       <= (w_state_next != IDLE);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_tick_cnt_next  = r_tick_cnt;
        w_bit_cnt_next   = r_bit_cnt;
        w_shift_next     = r_shift;
        w_rx_data_next   = rx_data;
        w_rx_valid_next  = 1'b0;
        w_frame_err_next = 1'b0;
        case (r_state)
            IDLE: begin
                // Edge-triggered: a line stuck low must go high again before retriggering.
                if (r_rx_prev && !w_rx_s) begin
                    w_state_next    = START;
                    w_tick_cnt_next = '0;
                end
            end
            START: begin
                if (baud_tick_16x) begin
                    if (r_tick_cnt == MID_TICK) begin
                        if (!w_rx_s) begin
                            w_state_next    = DATA;
                            w_tick_cnt_next = '0;
                            w_bit_cnt_next  = '0;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (baud_tick_16x) begin
                    if (r_tick_cnt == LAST_TICK) begin
                        w_shift_next    = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_tick_cnt_next = '0;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_state_next = STOP;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + TICK_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_tick_16x) begin
                    if (r_tick_cnt == LAST_TICK) begin
                        if (w_rx_s) begin
                            w_rx_data_next  = r_shift;
                            w_rx_valid_next = 1'b1;
                        end else begin
                            w_frame_err_next = 1'b1;
                        end
                        w_tick_cnt_next = '0;
                        w_state_next    = IDLE;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + TICK_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick_16x;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Observed events, collected by the monitor.
    logic [7:0] got_q[$];
    int         n_err_got    = 0;
    int         n_both       = 0;
    int         n_bad_change = 0;
    logic [7:0] prev_rx_data = 8'h00;

    // Reference model: frame-level expectations.
    logic [7:0] exp_q[$];
    int         exp_err  = 0;
    logic [7:0] exp_data = 8'h00;
    int         cmp_idx  = 0;

    uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_tick_16x (baud_tick_16x),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // One tick every 4 clks, i.e. 64 clks per nominal bit.
    initial begin
        baud_tick_16x = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 baud_tick_16x = 1'b1;
            @(posedge clk);
            #1 baud_tick_16x = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) got_q.push_back(rx_data);
            if (frame_err) n_err_got++;
            if (rx_valid && frame_err) n_both++;
            if ((rx_data !== prev_rx_data) && !rx_valid) n_bad_change++;
        end
        prev_rx_data = rx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop);
        if (stop) begin
            exp_q.push_back(d);
            exp_data = d;
        end else begin
            exp_err++;
        end
    endtask

    task automatic drive_bit(input logic b, input int clks);
        rx = b;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int clks);
        drive_bit(1'b1, clks);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
        drive_bit(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
        drive_bit(stop, bclk);
        model_frame(d, stop);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_valid_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (cmp_idx < got_q.size() && cmp_idx < exp_q.size()) begin
            check({tag, "_byte"}, 32'(got_q[cmp_idx]), 32'(exp_q[cmp_idx]));
            cmp_idx++;
        end
        check({tag, "_err_count"}, 32'(n_err_got), 32'(exp_err));
        check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_data));
        check({tag, "_busy_idle"}, 32'(busy), 32'(1'b0));
        check({tag, "_no_dual_pulse"}, 32'(n_both), 32'(0));
        check({tag, "_data_stable"}, 32'(n_bad_change), 32'(0));
    endtask

    initial begin
        int         busy_cnt;
        logic [7:0] d;
        logic       stop;
        int         bclk;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rx_data", 32'(rx_data), 32'(8'h00));
        check("reset_rx_valid", 32'(rx_valid), 32'(1'b0));
        check("reset_frame_err", 32'(frame_err), 32'(1'b0));
        check("reset_busy", 32'(busy), 32'(1'b0));
        rst_n = 1'b1;
        idle(100);

        // Single frame.
        send_frame(8'h55, 1'b1, BIT_CLKS);
        idle(96);
        check_all("single");

        // Back-to-back frames, no idle gap.
        send_frame(8'hA3, 1'b1, BIT_CLKS);
        send_frame(8'h00, 1'b1, BIT_CLKS);
        idle(96);
        check_all("b2b");

        // Glitch: low for 3 ticks, must be rejected at the mid-start check.
        busy_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (i == 12) rx = 1'b1;
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
        end
        check("glitch_busy_seen", 32'(busy_cnt > 0), 32'(1));
        check("glitch_busy_len", 32'(busy_cnt <= 33), 32'(1));
        check_all("glitch");

        // Good frame, then framing error followed by a long break.
        send_frame(8'h3C, 1'b1, BIT_CLKS);
        idle(96);
        check_all("pre_ferr");
        send_frame(8'hFF, 1'b0, BIT_CLKS);
        drive_bit(1'b0, 40 * BIT_CLKS);
        check_all("ferr_break");
        idle(128);
        send_frame(8'h5A, 1'b1, BIT_CLKS);
        idle(96);
        check_all("post_break");

        // Reset during bit 4 of 0x81, then a clean 0x7E.
        begin
            logic [7:0] partial;
            partial = 8'h81;
            drive_bit(1'b0, BIT_CLKS);
            for (int i = 0; i < 4; i++) drive_bit(partial[i], BIT_CLKS);
            drive_bit(partial[4], BIT_CLKS / 2);
        end
        rst_n = 1'b0;
        exp_data = 8'h00;
        #3;
        check("midreset_busy", 32'(busy), 32'(1'b0));
        check("midreset_rx_data", 32'(rx_data), 32'(8'h00));
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(200);
        check_all("after_reset");
        send_frame(8'h7E, 1'b1, BIT_CLKS);
        idle(96);
        check_all("post_reset_frame");

        // Bit-period skew of roughly +/-3%.
        send_frame(8'hC6, 1'b1, 66);
        idle(96);
        check_all("skew_slow");
        send_frame(8'hC6, 1'b1, 62);
        idle(96);
        check_all("skew_fast");

        // Randomized frames: random data, occasional bad stop bit, random skew and gap.
        for (int n = 0; n < 20; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            bclk = int'($urandom_range(62, 66));
            send_frame(d, stop, bclk);
            idle(80 + int'($urandom_range(0, 40)));
            check_all("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
